segre_id_issue_stage: RTL and testbench
=======================================

# segre_id_issue_stage

Parametrised issue stage that sits between decode and EX: it takes decoded, register-file-read instructions and holds them until their operands are safe to use. A per-register scoreboard tracks RAW and WAW hazards. Operands are resolved from the register file or from NUM_FWD bypass ports. Instructions leave through a valid/ready-handshaked output register. It is the successor of the fixed ID/EX register: it adds explicit hazard detection, bypassing, flush and back-pressure in place of an external hazard input.

## Interface
- WORD_SIZE, 32, operand/data width
- REG_SIZE, 5, register address width; scoreboard depth is 2**REG_SIZE
- NUM_FWD, 2, bypass ports; index 0 has highest priority (youngest producer)
- PAYLOAD_W, 64, opaque decoded-control bits (ALU opcode, memop, pipeline select) carried unmodified
- clk_i  in  1  clock
- rst_i  in  1  reset, synchronous, active-high
- id_valid_i / id_ready_o  in/out  1  upstream handshake
- rs_a_i, rs_b_i  in  REG_SIZE  source registers
- rs_a_used_i, rs_b_used_i  in  1  source actually read
- rd_i  in  REG_SIZE  destination; rd_we_i  in  1  destination written
- rf_data_a_i, rf_data_b_i  in  WORD_SIZE  register-file read data (RF writes through same cycle)
- payload_i  in  PAYLOAD_W  decoded control
- fwd_valid_i  in  NUM_FWD  bypass valid per port
- fwd_addr_i  in  NUM_FWD*REG_SIZE  bypass destination; fwd_data_i  in  NUM_FWD*WORD_SIZE  bypass value
- wb_valid_i  in  1, wb_addr_i  in  REG_SIZE  writeback retire, clears scoreboard
- flush_i  in  1  kill ID and output-register contents
- ex_valid_o / ex_ready_i  out/in  1  downstream handshake
- ex_op_a_o, ex_op_b_o  out  WORD_SIZE  resolved operands
- ex_rd_o  out  REG_SIZE; ex_rd_we_o  out  1; ex_payload_o  out  PAYLOAD_W
- stall_cnt_o  out  32  hazard-stall cycle counter

## Operation
- Scoreboard: pending[2**REG_SIZE], bit 0 is always 0. A register written to x0 never sets a bit. Reads of x0 return 0.
- Operand X (a/b) is ready if !rsX_used_i, or rsX==0, or !pending[rsX], or (SEGRE_ID_FWD_EN) some fwd_valid_i[k] with fwd_addr==rsX. If ports 0 and 1 both match, port 0's data is used.
- Operand value: forwarded data if matched, else rf_data.
- WAW: stall while rd_we_i && rd_i!=0 && pending[rd_i]. A forward match does not clear a WAW stall. This guarantees at most one outstanding producer per register.
- issue = id_valid_i && a_ready && b_ready && !waw && (!ex_valid_o || ex_ready_i) && !flush_i.
- id_ready_o = a_ready && b_ready && !waw && (!ex_valid_o || ex_ready_i) && !flush_i. It does not depend on id_valid_i.
- On issue, the output register loads the operands, rd, rd_we and payload; ex_valid_o<=1; pending[rd_i] is set if rd_we_i && rd_i!=0.
- Output drains: ex_valid_o && ex_ready_i && !issue -> ex_valid_o<=0.
- Hold: ex_valid_o && !ex_ready_i -> all ex_* outputs stay stable.
- wb_valid_i clears pending[wb_addr_i]. If the same register is set and cleared in the same cycle, set wins.
- flush_i: ex_valid_o<=0. If ex_valid_o && ex_rd_we_o, pending[ex_rd_o] is cleared. No issue occurs that cycle. An earlier-issued producer's wb still clears its own bit.
- stall_cnt_o increments on id_valid_i && !id_ready_o && !flush_i. It saturates at 32'hFFFF_FFFF.

## Timing
- Reset (rst_i high at a clk_i edge): ex_valid_o=0, ex_op_a_o=0, ex_op_b_o=0, ex_rd_o=0, ex_rd_we_o=0, ex_payload_o=0, all pending=0, stall_cnt_o=0.
- Reset mid-operation discards the held instruction and all scoreboard state in the same edge.
- Latency: 1 cycle from the issue edge to ex_valid_o.
- Throughput: 1 instruction/cycle with no hazards and ex_ready_i=1.
- Back-to-back RAW with forwarding: 0 bubbles if the producer's value arrives on a fwd port in the consumer's ID cycle.
- A wb-released register is usable in the same cycle wb_valid_i is high.
- id_ready_o and operand selection are combinational from the inputs and the scoreboard. All ex_* outputs come from registers.

## Configuration
- SEGRE_ID_FWD_EN defined: bypass matching is active as described.
- SEGRE_ID_FWD_EN undefined: the fwd_* ports are present but ignored. Operands are ready only when not pending, so consumers wait for wb_valid_i. Operand values always come from rf_data.

## Test plan
- Reset: hold rst_i 2 cycles during a held valid output -> next cycle ex_valid_o=0, stall_cnt_o=0, pending all 0.
- RAW, no forward: issue rd=5 (rd_we=1); next instruction uses rs_a=5 -> id_ready_o=0 until wb_valid_i=1, wb_addr_i=5 -> issues that cycle with rf_data_a_i=0x1234; stall_cnt_o equals the number of stall cycles.
- Forward priority (SEGRE_ID_FWD_EN): pending[7]; fwd0={7,0xAAAA}, fwd1={7,0xBBBB}, rs_b=7 -> ex_op_b_o=0xAAAA one cycle later, 0 bubbles.
- WAW + x0: pending[3], new rd=3 -> stalls even with fwd match for 3; rd=0 writes never stall and rs=0 yields operand 0.
- Back-pressure: ex_ready_i=0 for 4 cycles with ex_valid_o=1 -> ex_* stable, id_ready_o=0; ex_ready_i=1 -> next instruction loads the following edge.
- Flush: output holds rd=9 (rd_we=1), flush_i=1 -> ex_valid_o=0, pending[9]=0; a consumer of x9 then issues without a wb.

Source files
------------

// File: rtl/segre_id_issue_stage.sv
// segre_id_issue_stage: holds decoded instructions until their operands are
// hazard-free, then issues them into a valid/ready output register for EX.
//
// Parameters : WORD_SIZE, REG_SIZE, NUM_FWD, PAYLOAD_W
// Macro      : SEGRE_ID_FWD_EN enables operand bypass from the fwd_* ports;
//              when undefined those ports are present but ignored.
// Ports      : clk_i, rst_i (sync, active-high)
//              id_*   upstream handshake + decoded instruction + RF data
//              fwd_*  bypass ports (index 0 = youngest producer)
//              wb_*   writeback retire, clears the scoreboard
//              flush_i kills the ID instruction and the output register
//              ex_*   registered instruction towards EX
//              stall_cnt_o saturating stall-cycle counter
module segre_id_issue_stage #(
    parameter int WORD_SIZE = 32,
    parameter int REG_SIZE  = 5,
    parameter int NUM_FWD   = 2,
    parameter int PAYLOAD_W = 64
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          id_valid_i,
    output logic                          id_ready_o,
    input  logic [REG_SIZE-1:0]           rs_a_i,
    input  logic [REG_SIZE-1:0]           rs_b_i,
    input  logic                          rs_a_used_i,
    input  logic                          rs_b_used_i,
    input  logic [REG_SIZE-1:0]           rd_i,
    input  logic                          rd_we_i,
    input  logic [WORD_SIZE-1:0]          rf_data_a_i,
    input  logic [WORD_SIZE-1:0]          rf_data_b_i,
    input  logic [PAYLOAD_W-1:0]          payload_i,
    input  logic [NUM_FWD-1:0]            fwd_valid_i,
    input  logic [NUM_FWD*REG_SIZE-1:0]   fwd_addr_i,
    input  logic [NUM_FWD*WORD_SIZE-1:0]  fwd_data_i,
    input  logic                          wb_valid_i,
    input  logic [REG_SIZE-1:0]           wb_addr_i,
    input  logic                          flush_i,
    output logic                          ex_valid_o,
    input  logic                          ex_ready_i,
    output logic [WORD_SIZE-1:0]          ex_op_a_o,
    output logic [WORD_SIZE-1:0]          ex_op_b_o,
    output logic [REG_SIZE-1:0]           ex_rd_o,
    output logic                          ex_rd_we_o,
    output logic [PAYLOAD_W-1:0]          ex_payload_o,
    output logic [31:0]                   stall_cnt_o
);

    localparam int NREG = 2 ** REG_SIZE;

    logic [NREG-1:0]      pend_q, pend_d;
    logic [NREG-1:0]      busy;
    logic                 ex_valid_q;
    logic [WORD_SIZE-1:0] ex_op_a_q, ex_op_b_q;
    logic [REG_SIZE-1:0]  ex_rd_q;
    logic                 ex_rd_we_q;
    logic [PAYLOAD_W-1:0] ex_payload_q;
    logic [31:0]          stall_cnt_q;

    logic                 hit_a, hit_b;
    logic [WORD_SIZE-1:0] fwd_a, fwd_b;
    logic [WORD_SIZE-1:0] op_a, op_b;
    logic                 a_ready, b_ready, waw;
    logic                 can_accept, id_ready, issue;

    // Bypass match; scanning from the highest index down lets port 0 win.
    always_comb begin
        hit_a = 1'b0;
        hit_b = 1'b0;
        fwd_a = '0;
        fwd_b = '0;
`ifdef SEGRE_ID_FWD_EN
        for (int k = NUM_FWD - 1; k >= 0; k--) begin
            if (fwd_valid_i[k] &&
                fwd_addr_i[k*REG_SIZE +: REG_SIZE] == rs_a_i) begin
                hit_a = 1'b1;
                fwd_a = fwd_data_i[k*WORD_SIZE +: WORD_SIZE];
            end
            if (fwd_valid_i[k] &&
                fwd_addr_i[k*REG_SIZE +: REG_SIZE] == rs_b_i) begin
                hit_b = 1'b1;
                fwd_b = fwd_data_i[k*WORD_SIZE +: WORD_SIZE];
            end
        end
`endif
    end

`ifndef SEGRE_ID_FWD_EN
    logic fwd_unused;
    assign fwd_unused = ^{fwd_valid_i, fwd_addr_i, fwd_data_i};
`endif

    // A register retired this cycle is already free: the RF writes through.
    always_comb begin
        busy = pend_q;
        if (wb_valid_i) begin
            busy[wb_addr_i] = 1'b0;
        end
        busy[0] = 1'b0;
    end

    assign a_ready = !rs_a_used_i || (rs_a_i == '0) || !busy[rs_a_i] || hit_a;
    assign b_ready = !rs_b_used_i || (rs_b_i == '0) || !busy[rs_b_i] || hit_b;
    // A bypass never clears WAW: one outstanding producer per register.
    assign waw     = rd_we_i && (rd_i != '0) && busy[rd_i];

    assign op_a = (rs_a_i == '0) ? '0 : (hit_a ? fwd_a : rf_data_a_i);
    assign op_b = (rs_b_i == '0) ? '0 : (hit_b ? fwd_b : rf_data_b_i);

    assign can_accept = !ex_valid_q || ex_ready_i;
    assign id_ready   = a_ready && b_ready && !waw && can_accept && !flush_i;
    assign issue      = id_valid_i && id_ready;

    // Clear order: wb, then flush of the killed producer; a set wins last.
    always_comb begin
        pend_d = busy;
        if (flush_i && ex_valid_q && ex_rd_we_q) begin
            pend_d[ex_rd_q] = 1'b0;
        end
        if (issue && rd_we_i && (rd_i != '0)) begin
            pend_d[rd_i] = 1'b1;
        end
        pend_d[0] = 1'b0;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pend_q       <= '0;
            ex_valid_q   <= 1'b0;
            ex_op_a_q    <= '0;
            ex_op_b_q    <= '0;
            ex_rd_q      <= '0;
            ex_rd_we_q   <= 1'b0;
            ex_payload_q <= '0;
            stall_cnt_q  <= '0;
        end else begin
            pend_q <= pend_d;
            if (issue) begin
                ex_valid_q   <= 1'b1;
                ex_op_a_q    <= op_a;
                ex_op_b_q    <= op_b;
                ex_rd_q      <= rd_i;
                ex_rd_we_q   <= rd_we_i;
                ex_payload_q <= payload_i;
            end else if (flush_i || ex_ready_i) begin
                ex_valid_q <= 1'b0;
            end
            if (id_valid_i && !id_ready && !flush_i &&
                (stall_cnt_q != 32'hFFFF_FFFF)) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
        end
    end

    assign id_ready_o   = id_ready;
    assign ex_valid_o   = ex_valid_q;
    assign ex_op_a_o    = ex_op_a_q;
    assign ex_op_b_o    = ex_op_b_q;
    assign ex_rd_o      = ex_rd_q;
    assign ex_rd_we_o   = ex_rd_we_q;
    assign ex_payload_o = ex_payload_q;
    assign stall_cnt_o  = stall_cnt_q;

endmodule

// File: tb/tb_segre_id_issue_stage.sv
// tb_segre_id_issue_stage: directed table vectors plus hand-written
// sequences for reset, RAW, forwarding, WAW/x0, back-pressure and flush.
module tb_segre_id_issue_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid, id_ready;
    logic [4:0]  rs_a, rs_b, rd;
    logic        ua, ub, we;
    logic [31:0] rf_a, rf_b;
    logic [63:0] payload;
    logic [1:0]  fwd_valid;
    logic [9:0]  fwd_addr;
    logic [63:0] fwd_data;
    logic        wb_valid;
    logic [4:0]  wb_addr;
    logic        flush;
    logic        ex_valid, ex_ready;
    logic [31:0] ex_a, ex_b;
    logic [4:0]  ex_rd;
    logic        ex_we;
    logic [63:0] ex_pl;
    logic [31:0] stall_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    segre_id_issue_stage dut (
        .clk_i(clk), .rst_i(rst),
        .id_valid_i(id_valid), .id_ready_o(id_ready),
        .rs_a_i(rs_a), .rs_b_i(rs_b),
        .rs_a_used_i(ua), .rs_b_used_i(ub),
        .rd_i(rd), .rd_we_i(we),
        .rf_data_a_i(rf_a), .rf_data_b_i(rf_b),
        .payload_i(payload),
        .fwd_valid_i(fwd_valid), .fwd_addr_i(fwd_addr),
        .fwd_data_i(fwd_data),
        .wb_valid_i(wb_valid), .wb_addr_i(wb_addr),
        .flush_i(flush),
        .ex_valid_o(ex_valid), .ex_ready_i(ex_ready),
        .ex_op_a_o(ex_a), .ex_op_b_o(ex_b),
        .ex_rd_o(ex_rd), .ex_rd_we_o(ex_we),
        .ex_payload_o(ex_pl), .stall_cnt_o(stall_cnt)
    );

    typedef struct {
        logic [4:0]  ra, rb;
        logic        ua, ub;
        logic [4:0]  rd;
        logic        we;
        logic [31:0] fa, fb;
        logic [63:0] pl;
        logic        vin;
        logic        rdy_exp;
        logic        vout_exp;
        logic [31:0] a_exp, b_exp;
        logic [4:0]  rd_exp;
        logic        we_exp;
    } vec_t;

    vec_t vecs [7];

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        id_valid = 0; rs_a = 0; rs_b = 0; ua = 0; ub = 0;
        rd = 0; we = 0; rf_a = 0; rf_b = 0; payload = 0;
        fwd_valid = 0; fwd_addr = 0; fwd_data = 0;
        wb_valid = 0; wb_addr = 0; flush = 0; ex_ready = 1;
    endtask

    task automatic instr(input logic [4:0] ra, input logic [4:0] rb,
                         input logic a_u, input logic b_u,
                         input logic [4:0] d, input logic w,
                         input logic [31:0] da, input logic [31:0] db,
                         input logic [63:0] pl);
        id_valid = 1; rs_a = ra; rs_b = rb; ua = a_u; ub = b_u;
        rd = d; we = w; rf_a = da; rf_b = db; payload = pl;
    endtask

    task automatic do_reset();
        rst = 1;
        tick();
        tick();
        rst = 0;
    endtask

    initial begin
        idle();
        rst = 1;
        tick();
        tick();
        rst = 0;

        check("rst_valid", ex_valid, 0);
        check("rst_stall", stall_cnt, 0);
        check("rst_pl", ex_pl, 0);

        //          ra  rb  ua ub rd  we  rf_a       rf_b      payload
        //          vin rdy vo  a_exp      b_exp      rd  we
        vecs[0] = '{5'd1, 5'd2, 1, 1, 5'd10, 1, 32'h11, 32'h22, 64'h100,
                    1, 1, 1, 32'h11, 32'h22, 5'd10, 1};
        vecs[1] = '{5'd0, 5'd3, 1, 1, 5'd0, 1, 32'hDEAD, 32'h33, 64'h101,
                    1, 1, 1, 32'h0, 32'h33, 5'd0, 1};
        vecs[2] = '{5'd10, 5'd4, 0, 1, 5'd11, 1, 32'h55, 32'h44, 64'h102,
                    1, 1, 1, 32'h55, 32'h44, 5'd11, 1};
        vecs[3] = '{5'd10, 5'd4, 1, 1, 5'd12, 1, 32'h66, 32'h44, 64'h103,
                    1, 0, 0, 32'h0, 32'h0, 5'd0, 0};
        vecs[4] = '{5'd1, 5'd2, 1, 1, 5'd13, 1, 32'h1, 32'h2, 64'h104,
                    0, 1, 0, 32'h0, 32'h0, 5'd0, 0};
        vecs[5] = '{5'd0, 5'd0, 1, 1, 5'd0, 0, 32'hFFFF, 32'hFFFF, 64'h105,
                    1, 1, 1, 32'h0, 32'h0, 5'd0, 0};
        vecs[6] = '{5'd0, 5'd0, 0, 0, 5'd11, 1, 32'h0, 32'h0, 64'h106,
                    1, 0, 0, 32'h0, 32'h0, 5'd0, 0};

        for (int i = 0; i < 7; i++) begin
            instr(vecs[i].ra, vecs[i].rb, vecs[i].ua, vecs[i].ub,
                  vecs[i].rd, vecs[i].we, vecs[i].fa, vecs[i].fb,
                  vecs[i].pl);
            id_valid = vecs[i].vin;
            #1;
            check($sformatf("v%0d_ready", i), id_ready, vecs[i].rdy_exp);
            tick();
            check($sformatf("v%0d_valid", i), ex_valid, vecs[i].vout_exp);
            if (vecs[i].vout_exp) begin
                check($sformatf("v%0d_a", i), ex_a, vecs[i].a_exp);
                check($sformatf("v%0d_b", i), ex_b, vecs[i].b_exp);
                check($sformatf("v%0d_rd", i), ex_rd, vecs[i].rd_exp);
                check($sformatf("v%0d_we", i), ex_we, vecs[i].we_exp);
                check($sformatf("v%0d_pl", i), ex_pl, vecs[i].pl);
            end
        end
        idle();
        check("tbl_stall", stall_cnt, 2);

        // Reset while an instruction is held and x10/x11 are pending.
        ex_ready = 0;
        instr(5'd0, 5'd0, 0, 0, 5'd20, 1, 0, 0, 64'hABC);
        tick();
        id_valid = 0;
        check("hold_before_rst", ex_valid, 1);
        do_reset();
        check("rst2_valid", ex_valid, 0);
        check("rst2_stall", stall_cnt, 0);
        check("rst2_rd", ex_rd, 0);
        ex_ready = 1;
        instr(5'd10, 5'd20, 1, 1, 5'd11, 1, 32'h7, 32'h8, 64'h0);
        #1;
        check("rst2_pend_clear", id_ready, 1);
        idle();

        // RAW without forwarding: wait for wb of x5.
        do_reset();
        instr(5'd0, 5'd0, 0, 0, 5'd5, 1, 0, 0, 64'h1);
        tick();
        instr(5'd5, 5'd0, 1, 0, 5'd6, 1, 32'h1234, 0, 64'h2);
        for (int i = 0; i < 3; i++) begin
            #1;
            check($sformatf("raw_stall%0d", i), id_ready, 0);
            tick();
        end
        wb_valid = 1;
        wb_addr = 5;
        #1;
        check("raw_wb_ready", id_ready, 1);
        tick();
        idle();
        check("raw_valid", ex_valid, 1);
        check("raw_a", ex_a, 32'h1234);
        check("raw_stall_cnt", stall_cnt, 3);

        // Forward priority on rs_b = x7.
        do_reset();
        instr(5'd0, 5'd0, 0, 0, 5'd7, 1, 0, 0, 64'h3);
        tick();
        instr(5'd0, 5'd7, 0, 1, 5'd8, 1, 0, 32'hCCCC, 64'h4);
        fwd_valid = 2'b11;
        fwd_addr = {5'd7, 5'd7};
        fwd_data = {32'hBBBB, 32'hAAAA};
        #1;
`ifdef SEGRE_ID_FWD_EN
        check("fwd_ready", id_ready, 1);
        tick();
        check("fwd_valid", ex_valid, 1);
        check("fwd_b", ex_b, 32'hAAAA);
`else
        check("nofwd_ready", id_ready, 0);
        tick();
        check("nofwd_valid", ex_valid, 0);
`endif
        idle();

        // WAW on x3 is not cleared by a bypass; x0 never stalls.
        do_reset();
        instr(5'd0, 5'd0, 0, 0, 5'd3, 1, 0, 0, 64'h5);
        tick();
        instr(5'd0, 5'd0, 0, 0, 5'd3, 1, 0, 0, 64'h6);
        fwd_valid = 2'b01;
        fwd_addr = {5'd0, 5'd3};
        fwd_data = {32'h0, 32'h3333};
        #1;
        check("waw_stall", id_ready, 0);
        tick();
        fwd_valid = 0;
        instr(5'd0, 5'd0, 1, 0, 5'd0, 1, 32'h999, 0, 64'h7);
        #1;
        check("x0_ready", id_ready, 1);
        tick();
        check("x0_valid", ex_valid, 1);
        check("x0_a", ex_a, 0);
        idle();

        // Back-pressure: output holds instruction A for 4 cycles.
        do_reset();
        ex_ready = 0;
        instr(5'd0, 5'd0, 0, 0, 5'd12, 1, 0, 0, 64'hA0A0);
        tick();
        instr(5'd1, 5'd2, 1, 1, 5'd13, 1, 32'hB1, 32'hB2, 64'hB0B0);
        for (int i = 0; i < 4; i++) begin
            #1;
            check($sformatf("bp_ready%0d", i), id_ready, 0);
            tick();
            check($sformatf("bp_hold%0d", i),
                  {ex_valid, ex_we, ex_rd, ex_pl[15:0]},
                  {1'b1, 1'b1, 5'd12, 16'hA0A0});
        end
        ex_ready = 1;
        #1;
        check("bp_release", id_ready, 1);
        tick();
        idle();
        check("bp_next_pl", ex_pl, 64'hB0B0);
        check("bp_next_a", ex_a, 32'hB1);

        // Flush a held producer of x9; a consumer of x9 then issues.
        do_reset();
        ex_ready = 0;
        instr(5'd0, 5'd0, 0, 0, 5'd9, 1, 0, 0, 64'h9);
        tick();
        instr(5'd1, 5'd0, 1, 0, 5'd14, 1, 32'h1, 0, 64'hE);
        flush = 1;
        #1;
        check("flush_no_ready", id_ready, 0);
        tick();
        flush = 0;
        check("flush_valid", ex_valid, 0);
        check("flush_stall", stall_cnt, 0);
        instr(5'd9, 5'd0, 1, 0, 5'd15, 1, 32'h4242, 0, 64'hF);
        #1;
        check("flush_consumer", id_ready, 1);
        tick();
        idle();
        check("flush_cons_a", ex_a, 32'h4242);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
